// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one Data_mem port between the core MEM stage
// and the debug/loader port. Round-robin on ties, rejects misaligned or
// reserved-size requests with an error ack, and sequences each legal access
// through a one-cycle memory strobe followed by an ack (and a response cycle
// for loads, since Data_mem returns read data one cycle late).

module dmem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int D_ADD_WIDTH = 5
) (
    input  logic                   Clk,
    input  logic                   Rst,

    input  logic                   c_req,
    input  logic                   c_we,
    input  logic [D_ADD_WIDTH-1:0] c_addr,
    input  logic [1:0]             c_sel,
    input  logic [DATA_WIDTH-1:0]  c_wdata,
    output logic                   c_ack,
    output logic                   c_err,
    output logic [DATA_WIDTH-1:0]  c_rdata,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [D_ADD_WIDTH-1:0] d_addr,
    input  logic [1:0]             d_sel,
    input  logic [DATA_WIDTH-1:0]  d_wdata,
    output logic                   d_ack,
    output logic                   d_err,
    output logic [DATA_WIDTH-1:0]  d_rdata,

    output logic [DATA_WIDTH-1:0]  Mem_in,
    output logic [D_ADD_WIDTH-1:0] Mem_addr,
    output logic [1:0]             sel,
    output logic                   write,
    output logic                   read,
    input  logic [DATA_WIDTH-1:0]  Mem_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_DEBUG = 1'b1;

    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    logic [1:0]             r_state;
    logic                   r_lastWinner;
    logic                   r_owner;
    logic                   r_we;
    logic [D_ADD_WIDTH-1:0] r_addr;
    logic [1:0]             r_sel;
    logic [DATA_WIDTH-1:0]  r_wdata;

    logic                   w_anyReq;
    logic                   w_grantDebug;
    logic                   w_winWe;
    logic [D_ADD_WIDTH-1:0] w_winAddr;
    logic [1:0]             w_winSel;
    logic [DATA_WIDTH-1:0]  w_winWdata;
    logic                   w_illegal;
    logic                   w_inAccess;

    // Pick the winner: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        w_anyReq     = c_req | d_req;
        w_grantDebug = d_req & (~c_req | (r_lastWinner == PORT_CORE));
        if (w_grantDebug) begin
            w_winWe    = d_we;
            w_winAddr  = d_addr;
            w_winSel   = d_sel;
            w_winWdata = d_wdata;
        end else begin
            w_winWe    = c_we;
            w_winAddr  = c_addr;
            w_winSel   = c_sel;
            w_winWdata = c_wdata;
        end
        w_illegal = (w_winSel == SEL_RSVD)
                  | ((w_winSel == SEL_HALF) & w_winAddr[0])
                  | ((w_winSel == SEL_WORD) & (w_winAddr[1:0] != 2'b00));
    end

    // Strobes are gated by reset directly so an in-flight store never commits
    assign w_inAccess = (r_state == ACCESS);
    assign write      = Rst & w_inAccess & r_we;
    assign read       = Rst & w_inAccess & ~r_we;
    assign Mem_addr   = r_addr;
    assign sel        = r_sel;
    assign Mem_in     = r_wdata;

    // Transaction sequencer: accept in IDLE, strobe in ACCESS, collect load data in RESP
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state      <= IDLE;
            r_lastWinner <= PORT_DEBUG;
            r_owner      <= PORT_DEBUG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wdata      <= '0;
            c_ack        <= 1'b0;
            d_ack        <= 1'b0;
            c_err        <= 1'b0;
            d_err        <= 1'b0;
            c_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            c_err <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_lastWinner <= w_grantDebug;
                        r_owner      <= w_grantDebug;
                        r_we         <= w_winWe;
                        r_addr       <= w_winAddr;
                        r_sel        <= w_winSel;
                        r_wdata      <= w_winWdata;
                        if (w_illegal) begin
                            if (w_grantDebug) begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end else begin
                                c_ack <= 1'b1;
                                c_err <= 1'b1;
                            end
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_state <= IDLE;
                        if (r_owner == PORT_DEBUG) begin
                            d_ack <= 1'b1;
                        end else begin
                            c_ack <= 1'b1;
                        end
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_owner == PORT_DEBUG) begin
                        d_rdata <= Mem_out;
                        d_ack   <= 1'b1;
                    end else begin
                        c_rdata <= Mem_out;
                        c_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-002 The block SHALL have parameter D_ADD_WIDTH, default 5, meaning byte-address width into Data_mem.
REQ-003 The block SHALL have port Clk, input, 1 bit, meaning the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit, meaning reset; synchronous, active-low.
REQ-005 The block SHALL have ports c_req, c_we (1 bit), c_addr (D_ADD_WIDTH), c_sel (2), c_wdata (DATA_WIDTH), all inputs, meaning the core MEM-stage request, write-enable, address, size and store data.
REQ-006 The block SHALL have outputs c_ack (1), c_err (1) and c_rdata (DATA_WIDTH), meaning core completion pulse, error flag and load data.
REQ-007 The block SHALL have ports d_req, d_we, d_addr, d_sel, d_wdata (inputs) and d_ack, d_err, d_rdata (outputs), meaning the debug/loader port, widths identical to the core port.
REQ-008 The block SHALL have outputs Mem_in (DATA_WIDTH), Mem_addr (D_ADD_WIDTH), sel (2), write (1), read (1) and input Mem_out (DATA_WIDTH), meaning the Data_mem port.

Function
REQ-009 sel/c_sel/d_sel encoding SHALL be 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 The FSM SHALL have states IDLE, ACCESS, RESP; reset state IDLE.
REQ-011 In IDLE, with at least one req high at a rising edge, the block SHALL select a winner, latch its we/addr/sel/wdata and record it as last_winner.
REQ-012 Arbitration SHALL be round-robin: a lone requester wins; if both request, the one not equal to last_winner wins; last_winner resets to debug, so core wins the first tie.
REQ-013 A request SHALL be illegal if sel=11, or sel=01 with addr[0]=1, or sel=10 with addr[1:0]!=00.
REQ-014 An illegal winning request SHALL remain in IDLE, pulse that requester's ack and err for one cycle after the edge, and never assert write or read.
REQ-015 A legal winning request SHALL move IDLE->ACCESS; in ACCESS, Mem_addr/sel/Mem_in SHALL equal the latched values and write=latched we, read=~latched we, for exactly one cycle.
REQ-016 From ACCESS, a write SHALL go to IDLE and pulse the winner's ack in the following cycle (write ack 2 cycles after the accepting edge).
REQ-017 From ACCESS, a read SHALL go to RESP; Data_mem returns Mem_out one cycle after read, and at the RESP->IDLE edge the block SHALL register Mem_out into the winner's rdata and pulse its ack (read ack 3 cycles after the accepting edge).
REQ-018 c_rdata/d_rdata SHALL hold their last loaded value until that port's next read completion.
REQ-019 write and read SHALL be 0 in IDLE and RESP; Mem_addr/sel/Mem_in SHALL hold the last latched values outside ACCESS.
REQ-020 ack and err SHALL be single-cycle pulses, never asserted on both ports in the same cycle; err SHALL be 0 whenever ack is 0.
REQ-021 Requesters SHALL hold req and payload stable until ack; req high in the ack cycle SHALL be treated as a new request sampled at that cycle's edge.
REQ-022 Deasserting req after acceptance SHALL NOT abort the transaction; req from the loser SHALL be held pending and served next in IDLE.
REQ-023 Requests arriving while not in IDLE SHALL NOT be sampled until the FSM returns to IDLE.

Reset
REQ-024 While Rst=0, write and read SHALL be forced to 0 combinationally so no in-flight store commits.
REQ-025 At a rising edge with Rst=0, the block SHALL enter IDLE, clear c_ack, d_ack, c_err, d_err, c_rdata, d_rdata, Mem_in, Mem_addr and sel to 0, and set last_winner=debug.
REQ-026 A transaction interrupted by reset SHALL be dropped without ack.

Verification
REQ-027 Core word write addr=0x04 data=0xDEADBEEF, then core word read addr=0x04 -> write=1 one cycle, c_ack 2 cycles after acceptance; read=1 one cycle, c_ack with c_rdata=0xDEADBEEF 3 cycles after acceptance.
REQ-028 c_req and d_req both high from reset, each reading, held until ack -> grant order core, debug, core, debug; no overlapping acks.
REQ-029 Debug halfword write addr=0x03 -> d_ack=1, d_err=1 next cycle, write never asserted; sel=11 from core -> c_err=1 likewise.
REQ-030 Rst driven low during ACCESS of a core write -> write=0 that cycle, no c_ack, memory unchanged at that address on readback.
REQ-031 Core byte read addr=0x01 with d_req rising during ACCESS -> core completes first, debug accepted in the IDLE cycle after c_ack's edge.
REQ-032 Core keeps c_req high through c_ack with a new write -> second transaction accepted at the ack cycle edge, back-to-back with no idle gap.
